// File: rtl/enemy_ai.sv
// Enemy AI controller: turns player/enemy state into registered motion command
// strobes using a decision FSM, a guard/duck hold timer, a jump cooldown and an LFSR.
module enemy_ai #(
  parameter int          NEAR_X     = 64,
  parameter int          FAR_X      = 192,
  parameter int          DECIDE_CYC = 8,
  parameter int          HOLD_CYC   = 6,
  parameter int          JUMP_CD    = 24,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [10:0] p_x,
  input  logic               p_isJ,
  input  logic               p_atk,
  input  logic signed [10:0] e_x,
  input  logic               e_isJ,
  output logic               right,
  output logic               left,
  output logic               jump,
  output logic               squat,
  output logic               defend
);

  localparam int DW = $clog2(DECIDE_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int JW = $clog2(JUMP_CD + 1);

  typedef enum logic [2:0] {IDLE, APPROACH, RETREAT, GUARD, DUCK} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   dcnt, dcnt_nx;
  logic [HW-1:0]   hcnt, hcnt_nx;
  logic [JW-1:0]   jcd, jcd_nx;
  logic [15:0]     lfsr, lfsr_nx;
  logic            p_isJ_q;
  logic            right_nx, left_nx, jump_nx, squat_nx, defend_nx;

  logic signed [11:0] dx;
  logic [11:0]        adx;
  logic               near, far, guard_hit, fire;
  logic [2:0]         rnd;

  assign dx        = {e_x[10], e_x} - {p_x[10], p_x};
  assign adx       = dx[11] ? 12'(-dx) : 12'(dx);
  assign near      = adx < 12'(NEAR_X);
  assign far       = adx > 12'(FAR_X);
  assign rnd       = lfsr[2:0];
  assign guard_hit = p_atk && near;
  assign lfsr_nx   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // State, timers and registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dcnt    <= '0;
      hcnt    <= '0;
      jcd     <= '0;
      lfsr    <= LFSR_SEED;
      p_isJ_q <= 1'b0;
      right   <= 1'b0;
      left    <= 1'b0;
      jump    <= 1'b0;
      squat   <= 1'b0;
      defend  <= 1'b0;
    end else begin
      state   <= state_nx;
      dcnt    <= dcnt_nx;
      hcnt    <= hcnt_nx;
      jcd     <= jcd_nx;
      lfsr    <= lfsr_nx;
      p_isJ_q <= p_isJ;
      right   <= right_nx;
      left    <= left_nx;
      jump    <= jump_nx;
      squat   <= squat_nx;
      defend  <= defend_nx;
    end
  end

  // Next state: a reactive guard outranks both hold countdown and periodic decisions.
  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    hcnt_nx  = hcnt;
    if (guard_hit) begin
      state_nx = GUARD;
      hcnt_nx  = HW'(HOLD_CYC);
      dcnt_nx  = '0;
    end else if (state == GUARD || state == DUCK) begin
      hcnt_nx = hcnt - HW'(1);
      if (hcnt == HW'(1)) begin
        state_nx = IDLE;
        dcnt_nx  = '0;
      end
    end else if (dcnt == DW'(DECIDE_CYC - 1)) begin
      dcnt_nx = '0;
      if (far) begin
        state_nx = APPROACH;
      end else if (near) begin
        if (rnd == 3'd7) begin
          state_nx = DUCK;
          hcnt_nx  = HW'(HOLD_CYC);
        end else if (rnd[1:0] == 2'd0) begin
          state_nx = RETREAT;
        end else begin
          state_nx = IDLE;
        end
      end else begin
        state_nx = rnd[0] ? APPROACH : IDLE;
      end
    end else begin
      dcnt_nx = dcnt + DW'(1);
    end
  end

  // Output decode from the next state; dx > 0 means the player is to the left.
  always_comb begin
    right_nx  = 1'b0;
    left_nx   = 1'b0;
    squat_nx  = 1'b0;
    defend_nx = 1'b0;
    case (state_nx)
      APPROACH: begin
        left_nx  = (dx > 0);
        right_nx = (dx < 0);
      end
      RETREAT: begin
        left_nx  = (dx < 0);
        right_nx = (dx > 0);
      end
      GUARD:   defend_nx = 1'b1;
      DUCK:    squat_nx  = 1'b1;
      default: ;
    endcase
    fire    = p_isJ && !p_isJ_q && (adx <= 12'(FAR_X)) && !e_isJ && (jcd == '0)
              && (state_nx != GUARD) && (state_nx != DUCK);
    jump_nx = fire;
    if (fire)
      jcd_nx = JW'(JUMP_CD);
    else if (jcd != '0)
      jcd_nx = jcd - JW'(1);
    else
      jcd_nx = jcd;
  end

endmodule

// File: tb/tb_enemy_ai.sv
// Self-checking bench for enemy_ai: directed scenarios plus random play against a
// behavioural model of the enemy's decision rules.
module tb_enemy_ai;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [10:0] p_x = '0;
  logic signed [10:0] e_x = '0;
  logic              p_isJ = 1'b0, p_atk = 1'b0, e_isJ = 1'b0;
  logic              right, left, jump, squat, defend;

  int total = 0;
  int bad   = 0;

  enemy_ai dut (
    .clk(clk), .rst_n(rst_n), .p_x(p_x), .p_isJ(p_isJ), .p_atk(p_atk),
    .e_x(e_x), .e_isJ(e_isJ), .right(right), .left(left), .jump(jump),
    .squat(squat), .defend(defend)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 approach, 2 retreat, 3 guard, 4 duck.
  int          m_mode, m_tick, m_hold, m_cool;
  bit          m_prevj;
  logic [15:0] m_rng;
  logic        m_right, m_left, m_jump, m_squat, m_defend;

  always @(posedge clk or negedge rst_n) begin
    int d, a, r, nm;
    bit near, far, fire;
    if (!rst_n) begin
      m_mode = 0; m_tick = 0; m_hold = 0; m_cool = 0; m_prevj = 0;
      m_rng = 16'hACE1;
      {m_right, m_left, m_jump, m_squat, m_defend} = '0;
    end else begin
      d    = int'(e_x) - int'(p_x);
      a    = (d < 0) ? -d : d;
      near = (a < 64);
      far  = (a > 192);
      r    = int'(m_rng) % 8;
      if (p_atk && near) begin
        nm = 3; m_hold = 6; m_tick = 0;
      end else if (m_mode >= 3) begin
        nm = m_mode;
        if (m_hold == 1) begin nm = 0; m_tick = 0; end
        m_hold = m_hold - 1;
      end else if (m_tick == 7) begin
        m_tick = 0;
        if (far)              nm = 1;
        else if (near) begin
          if (r == 7)          begin nm = 4; m_hold = 6; end
          else if (r % 4 == 0) nm = 2;
          else                 nm = 0;
        end else               nm = (r % 2 == 1) ? 1 : 0;
      end else begin
        m_tick = m_tick + 1;
        nm = m_mode;
      end
      m_mode   = nm;
      m_left   = (nm == 1 && d > 0) || (nm == 2 && d < 0);
      m_right  = (nm == 1 && d < 0) || (nm == 2 && d > 0);
      m_defend = (nm == 3);
      m_squat  = (nm == 4);
      fire     = p_isJ && !m_prevj && (a <= 192) && !e_isJ && (m_cool == 0) && (nm < 3);
      m_jump   = fire;
      m_cool   = fire ? 24 : ((m_cool > 0) ? m_cool - 1 : 0);
      m_prevj  = p_isJ;
      m_rng    = (m_rng >> 1) ^ (m_rng[0] ? 16'hB400 : 16'h0000);
    end
  end

  always @(posedge clk) begin
    #1;
    total++;
    if ({right, left, jump, squat, defend} !== {m_right, m_left, m_jump, m_squat, m_defend}) begin
      bad++;
      $display("FAIL model_cmp t=%0t got rljsd=%b want=%b", $time,
               {right, left, jump, squat, defend}, {m_right, m_left, m_jump, m_squat, m_defend});
    end
    total++;
    if ((right & left) | (jump & squat) | (defend & jump)) begin
      bad++;
      $display("FAIL invariant t=%0t got rljsd=%b", $time, {right, left, jump, squat, defend});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
    else $display("check %s = %0d", name, got);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; p_atk = 1'b0; p_isJ = 1'b0; e_isJ = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    // Reset with random inputs
    rst_n = 1'b0;
    p_x = 11'($urandom_range(0, 1000)); e_x = 11'($urandom_range(0, 1000));
    p_atk = 1'($urandom); p_isJ = 1'($urandom); e_isJ = 1'($urandom);
    tick(3);
    chk("reset_outputs", int'({right, left, jump, squat, defend}), 0);

    // Approach, player to the left
    do_reset();
    e_x = 11'sd560; p_x = 11'sd100;
    tick(7);
    chk("approach_before_decision", int'(left), 0);
    tick(1);
    chk("approach_left_edge8", int'(left), 1);
    tick(20);
    chk("approach_left_held", int'(left), 1);
    chk("approach_right_never", int'(right), 0);

    // Coincident positions while approaching
    e_x = 11'sd100;
    tick(1);
    chk("coincident_lr", int'({left, right}), 0);

    // Approach, player to the right
    do_reset();
    e_x = 11'sd100; p_x = 11'sd560;
    tick(8);
    chk("approach_right_edge8", int'(right), 1);
    chk("approach_left_off", int'(left), 0);

    // Guard on a one-clock attack at close range
    do_reset();
    e_x = 11'sd140; p_x = 11'sd100;
    p_atk = 1'b1;
    tick(1);
    p_atk = 1'b0;
    chk("guard_defend_on", int'(defend), 1);
    chk("guard_lr_off", int'({left, right}), 0);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin tick(1); cnt += int'(defend); end
    chk("guard_defend_len", cnt, 6);

    // Attack at long range: no guard
    e_x = 11'sd300;
    p_atk = 1'b1;
    tick(1);
    p_atk = 1'b0;
    cnt = int'(defend);
    for (int i = 0; i < 10; i++) begin tick(1); cnt += int'(defend); end
    chk("far_attack_no_defend", cnt, 0);

    // Guard beats a decision on the same clock
    do_reset();
    e_x = 11'sd140; p_x = 11'sd100;
    tick(7);
    p_atk = 1'b1;
    tick(1);
    p_atk = 1'b0;
    chk("guard_beats_decision", int'(defend), 1);
    chk("guard_beats_decision_lr", int'({left, right, squat}), 0);

    // Jump cooldown
    do_reset();
    e_x = 11'sd200; p_x = 11'sd100;
    p_isJ = 1'b1;
    tick(1);
    chk("jump_first", int'(jump), 1);
    p_isJ = 1'b0;
    tick(1);
    chk("jump_one_clock", int'(jump), 0);
    tick(8);
    p_isJ = 1'b1;
    tick(1);
    chk("jump_in_cooldown", int'(jump), 0);
    p_isJ = 1'b0;
    tick(19);
    p_isJ = 1'b1;
    tick(1);
    chk("jump_after_cooldown", int'(jump), 1);
    p_isJ = 1'b0;
    tick(40);
    e_isJ = 1'b1; p_isJ = 1'b1;
    tick(1);
    chk("jump_enemy_airborne", int'(jump), 0);
    e_isJ = 1'b0; p_isJ = 1'b0;

    // Random play
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        p_x = 11'(int'($urandom_range(0, 1200)) - 600);
        if ($urandom_range(0, 3) == 0)
          e_x = 11'(int'($urandom_range(0, 1800)) - 900);
        else
          e_x = 11'(int'(p_x) + int'($urandom_range(0, 600)) - 300);
      end
      p_atk = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) p_isJ = ~p_isJ;
      e_isJ = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1999) == 0) rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
